shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle controller for the shift unit (RegDesloc) and its two input muxes: the entry mux (A / B / IR15_0) and the shift-amount mux.
- Accepts one shift operation per start pulse from the main control FSM.
- Drives the mux selects and the RegDesloc command through a LOAD -> SHIFT -> DONE sequence.
- Signals completion so the main FSM can write the result back.

Parameters:
- LOAD_CYCLES, 1, cycles spent in LOAD with the shifter load command asserted, so the entry mux can settle; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from the main FSM; sampled only in IDLE.
- op  input  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 LUI, 111 illegal.
- EntryCtrl  output  2  entry mux select: 00 IR15_0, 01 B, 10 A; 11 never driven.
- ShamtCtrl  output  2  shift-amount mux select: 00 IR[10:6], 01 A[4:0], 10 constant 16; 11 never driven.
- ShiftCtrl  output  3  RegDesloc command: 000 hold, 001 load, 010 shift left, 011 shift right logical, 100 shift right arithmetic.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle pulse in DONE; the RegDesloc output is valid in this cycle.
- err  output  1  one-cycle pulse on start with op=111.

Behaviour:
Reset:
- State IDLE; op register and counter cleared.
- Outputs: EntryCtrl=00, ShamtCtrl=00, ShiftCtrl=000, busy=0, done=0, err=0.
- Reset has priority over everything, including mid-sequence. Any operation in flight is abandoned with no done pulse.

States: IDLE, LOAD, SHIFT, DONE.

IDLE:
- Outputs as at reset.
- start=1 with op != 111: latch op, clear counter, go to LOAD.
- start=1 with op=111: err=1 next cycle, stay in IDLE, busy stays 0.
- start=0: stay in IDLE.

LOAD:
- ShiftCtrl=001; EntryCtrl and ShamtCtrl come from the latched op (mapping below).
- Counter increments each cycle.
- Transition to SHIFT after LOAD_CYCLES cycles in LOAD.

SHIFT (exactly 1 cycle):
- ShiftCtrl = the shift command for the op; selects unchanged.
- Next state DONE.

DONE (exactly 1 cycle):
- done=1, ShiftCtrl=000, selects held.
- Next state IDLE.

Op to select/command mapping (EntryCtrl / ShamtCtrl / shift command):
- SLL: 01 / 00 / 010
- SRL: 01 / 00 / 011
- SRA: 01 / 00 / 100
- SLLV: 01 / 01 / 010
- SRLV: 01 / 01 / 011
- SRAV: 01 / 01 / 100
- LUI: 00 / 10 / 010

Timing:
- All outputs are registered, changing on the clk edge after the state change.
- Selects are stable from the first LOAD cycle through DONE; they never change mid-sequence.
- Latency from start-accept edge to done: LOAD_CYCLES + 2 cycles (3 at default).
- busy=1 in LOAD, SHIFT and DONE.

Boundary conditions:
- start while busy: ignored, not queued; the latched op is unchanged.
- op changing during a sequence: no effect, because op is latched at accept.
- start in the same cycle the sequencer returns to IDLE: accepted only if sampled in IDLE, i.e. at the earliest the cycle after DONE.
- start asserted continuously: back-to-back operations, one every LOAD_CYCLES + 3 cycles, with one IDLE cycle between them.

Test Plan:
1. Reset, then start with op=000 (SLL): LOAD for 1 cycle with ShiftCtrl=001, EntryCtrl=01, ShamtCtrl=00; next cycle ShiftCtrl=010; next cycle done=1, ShiftCtrl=000; busy high for exactly 3 cycles.
2. op=110 (LUI) with IR15_0=16'h1234 and a behavioural RegDesloc model: EntryCtrl=00, ShamtCtrl=10 throughout; at done the model output is 32'h12340000.
3. op=101 (SRAV) with B=32'h80000000, A[4:0]=4: ShamtCtrl=01, command 100; model output at done is 32'hF8000000.
4. op=111: err pulses once, busy=0, ShiftCtrl stays 000, no done. Then start op=001 (SRL) in the following cycle and confirm a normal sequence.
5. start pulsed again during SHIFT with a different op: ignored; the original op completes and exactly one done pulse occurs. Reset asserted in LOAD: all outputs return to reset values next cycle and no done is produced.
6. LOAD_CYCLES=3 with start held high: LOAD lasts 3 cycles, done arrives 5 cycles after accept, and the second operation is accepted the cycle after the first DONE.

Source files
------------

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle controller for the shift unit (RegDesloc) and its two input
// muxes. One shift operation is accepted per start pulse from the main control
// FSM. The sequencer then drives the entry-mux select, the shift-amount-mux
// select and the RegDesloc command through a LOAD -> SHIFT -> DONE sequence.
// A done pulse tells the main FSM that the RegDesloc output is valid for
// write-back.
//
// State table:
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_IDLE  | waiting for start; all outputs inactive
//   S_LOAD  | shifter load command; entry mux settles (LOAD_CYCLES cycles)
//   S_SHIFT | shift command for the latched op (1 cycle)
//   S_DONE  | done pulse; shifter holds; result valid (1 cycle)
//
// Parameters:
//   LOAD_CYCLES  cycles spent in LOAD with the load command asserted (1..4)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle request; only sampled in IDLE
//   op[2:0]    in   000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV,
//                   110 LUI, 111 illegal
//   EntryCtrl  out  entry mux select: 00 IR15_0, 01 B, 10 A
//   ShamtCtrl  out  shift-amount select: 00 IR[10:6], 01 A[4:0], 10 const 16
//   ShiftCtrl  out  RegDesloc command: 000 hold, 001 load, 010 sll,
//                   011 srl, 100 sra
//   busy       out  high while a sequence is in LOAD, SHIFT or DONE
//   done       out  one-cycle pulse; RegDesloc output valid this cycle
//   err        out  one-cycle pulse after a start with op=111 in IDLE
//
// All outputs are registered. They are decoded from the current state and
// loaded on the next clock edge, so they lag the state register by one cycle.
// That lag is what gives the LOAD_CYCLES + 2 cycle accept-to-done latency.
// -----------------------------------------------------------------------------
module shift_sequencer #(
  parameter int LOAD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  output logic [1:0] EntryCtrl,
  output logic [1:0] ShamtCtrl,
  output logic [2:0] ShiftCtrl,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (LOAD_CYCLES < 1 || LOAD_CYCLES > 4) begin : g_bad_load_cycles
    $error("shift_sequencer: LOAD_CYCLES must be in 1..4");
  end

  // Operation codes
  localparam logic [2:0] OP_SLL     = 3'b000;
  localparam logic [2:0] OP_SRL     = 3'b001;
  localparam logic [2:0] OP_SRA     = 3'b010;
  localparam logic [2:0] OP_SLLV    = 3'b011;
  localparam logic [2:0] OP_SRLV    = 3'b100;
  localparam logic [2:0] OP_SRAV    = 3'b101;
  localparam logic [2:0] OP_LUI     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // RegDesloc commands
  localparam logic [2:0] CMD_HOLD = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_SLL  = 3'b010;
  localparam logic [2:0] CMD_SRL  = 3'b011;
  localparam logic [2:0] CMD_SRA  = 3'b100;

  // Mux selects
  localparam logic [1:0] ENTRY_IR = 2'b00;
  localparam logic [1:0] ENTRY_B  = 2'b01;
  localparam logic [1:0] SHAMT_IR = 2'b00;
  localparam logic [1:0] SHAMT_A  = 2'b01;
  localparam logic [1:0] SHAMT_16 = 2'b10;

  // Counter value seen in the last LOAD cycle
  localparam logic [2:0] CNT_LAST = 3'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;

  logic [1:0] entry_d;
  logic [1:0] shamt_d;
  logic [2:0] shift_d;
  logic       busy_d;
  logic       done_d;
  logic       err_d;

  // Select/command decode of the latched op
  logic [1:0] op_entry;
  logic [1:0] op_shamt;
  logic [2:0] op_cmd;

  always_comb begin
    op_entry = ENTRY_B;
    op_shamt = SHAMT_IR;
    op_cmd   = CMD_SLL;
    case (op_q)
      OP_SLL:  op_cmd = CMD_SLL;
      OP_SRL:  op_cmd = CMD_SRL;
      OP_SRA:  op_cmd = CMD_SRA;
      OP_SLLV: begin
        op_shamt = SHAMT_A;
        op_cmd   = CMD_SLL;
      end
      OP_SRLV: begin
        op_shamt = SHAMT_A;
        op_cmd   = CMD_SRL;
      end
      OP_SRAV: begin
        op_shamt = SHAMT_A;
        op_cmd   = CMD_SRA;
      end
      OP_LUI: begin
        op_entry = ENTRY_IR;
        op_shamt = SHAMT_16;
        op_cmd   = CMD_SLL;
      end
      // The illegal op is never latched, so this arm is unreachable.
      default: op_cmd = CMD_SLL;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    entry_d = ENTRY_IR;
    shamt_d = SHAMT_IR;
    shift_d = CMD_HOLD;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            op_d    = op;
            cnt_d   = 3'd0;
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        entry_d = op_entry;
        shamt_d = op_shamt;
        shift_d = CMD_LOAD;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        entry_d = op_entry;
        shamt_d = op_shamt;
        shift_d = op_cmd;
        busy_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        // Selects stay put so the result path is still stable when the
        // main FSM writes it back.
        entry_d = op_entry;
        shamt_d = op_shamt;
        shift_d = CMD_HOLD;
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'd0;
      cnt_q     <= 3'd0;
      EntryCtrl <= ENTRY_IR;
      ShamtCtrl <= SHAMT_IR;
      ShiftCtrl <= CMD_HOLD;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      EntryCtrl <= entry_d;
      ShamtCtrl <= shamt_d;
      ShiftCtrl <= shift_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer. Two instances are used:
// u_dut1 runs with LOAD_CYCLES=1 and drives a behavioural RegDesloc datapath.
// u_dut3 runs with LOAD_CYCLES=3 and exercises start being held high.
// Expected control outputs come from a timeline model indexed by the number of
// cycles since the accept edge. Expected shift results come from plain
// arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start1, start3;
  logic [2:0] op1, op3;

  logic [1:0] entry1, shamt1, entry3, shamt3;
  logic [2:0] shift1, shift3;
  logic       busy1, done1, err1, busy3, done3, err3;

  shift_sequencer #(.LOAD_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .op        (op1),
    .EntryCtrl (entry1),
    .ShamtCtrl (shamt1),
    .ShiftCtrl (shift1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1)
  );

  shift_sequencer #(.LOAD_CYCLES(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .start     (start3),
    .op        (op3),
    .EntryCtrl (entry3),
    .ShamtCtrl (shamt3),
    .ShiftCtrl (shift3),
    .busy      (busy3),
    .done      (done3),
    .err       (err3)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural RegDesloc and input muxes driven by u_dut1
  logic [31:0] a_val, b_val, sreg;
  logic [15:0] ir_val;
  logic [31:0] entry_val;
  logic [4:0]  amt;

  assign entry_val = (entry1 == 2'b00) ? {16'h0000, ir_val} :
                     (entry1 == 2'b01) ? b_val : a_val;
  assign amt = (shamt1 == 2'b00) ? ir_val[10:6] :
               (shamt1 == 2'b01) ? a_val[4:0] : 5'd16;

  always @(posedge clk) begin
    if (reset) sreg <= 32'h0;
    else begin
      case (shift1)
        3'b001:  sreg <= entry_val;
        3'b010:  sreg <= sreg << amt;
        3'b011:  sreg <= sreg >> amt;
        3'b100:  sreg <= $unsigned($signed(sreg) >>> amt);
        default: sreg <= sreg;
      endcase
    end
  end

  // Result of each op expressed directly as an arithmetic operation
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [15:0] ir);
    logic [4:0] sh_i;
    logic [4:0] sh_a;
    sh_i = ir[10:6];
    sh_a = a[4:0];
    case (op)
      3'd0:    return b << sh_i;
      3'd1:    return b >> sh_i;
      3'd2:    return $unsigned($signed(b) >>> sh_i);
      3'd3:    return b << sh_a;
      3'd4:    return b >> sh_a;
      3'd5:    return $unsigned($signed(b) >>> sh_a);
      3'd6:    return {ir, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // {entry, shamt, command} per op, from the mapping table
  function automatic logic [6:0] op_table(input logic [2:0] op);
    case (op)
      3'd0:    return {2'b01, 2'b00, 3'b010};
      3'd1:    return {2'b01, 2'b00, 3'b011};
      3'd2:    return {2'b01, 2'b00, 3'b100};
      3'd3:    return {2'b01, 2'b01, 3'b010};
      3'd4:    return {2'b01, 2'b01, 3'b011};
      3'd5:    return {2'b01, 2'b01, 3'b100};
      3'd6:    return {2'b00, 2'b10, 3'b010};
      default: return 7'h00;
    endcase
  endfunction

  // Expected {busy, done, err, entry, shamt, shift} p cycles after the accept
  // edge. Outputs lag the accept by one cycle, so p=1..lc is LOAD, p=lc+1 is
  // SHIFT and p=lc+2 is DONE.
  function automatic logic [9:0] exp_vec(input logic [2:0] op, input int p,
                                         input int lc);
    logic [6:0] t;
    logic [2:0] cmd;
    t = op_table(op);
    if (p < 1 || p > lc + 2) return 10'h000;
    if (p <= lc)          cmd = 3'b001;
    else if (p == lc + 1) cmd = t[2:0];
    else                  cmd = 3'b000;
    return {1'b1, (p == lc + 2), 1'b0, t[6:3], cmd};
  endfunction

  function automatic logic [9:0] vec1();
    return {busy1, done1, err1, entry1, shamt1, shift1};
  endfunction

  function automatic logic [9:0] vec3();
    return {busy3, done3, err3, entry3, shamt3, shift3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation on u_dut1 starting from the current cycle. With noisy
  // set, random start/op values are driven while the sequencer cannot accept.
  task automatic run_op1(input logic [2:0] op, input logic noisy);
    logic [31:0] exp_r;
    exp_r  = ref_result(op, a_val, b_val, ir_val);
    start1 = 1'b1;
    op1    = op;
    for (int j = 0; j <= 4; j++) begin
      step();
      total++;
      if (vec1() !== exp_vec(op, j, 1)) begin
        bad++;
        $display("FAIL ctrl1 op=%0d p=%0d got=%h want=%h", op, j, vec1(),
                 exp_vec(op, j, 1));
      end
      if (j == 3) begin
        total++;
        if (sreg !== exp_r) begin
          bad++;
          $display("FAIL result op=%0d got=%h want=%h", op, sreg, exp_r);
        end
      end
      if (noisy && j <= 2) begin
        start1 = 1'($urandom_range(0, 1));
        op1    = 3'($urandom_range(0, 7));
      end else begin
        start1 = 1'b0;
        op1    = 3'($urandom_range(0, 7));
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    op1    = 3'd0;
    op3    = 3'd0;
    a_val  = 32'h0;
    b_val  = 32'h0;
    ir_val = 16'h0;
    step();
    step();
    total++;
    if (vec1() !== 10'h000) begin
      bad++;
      $display("FAIL reset1 got=%h want=000", vec1());
    end
    total++;
    if (vec3() !== 10'h000) begin
      bad++;
      $display("FAIL reset3 got=%h want=000", vec3());
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_sll();
    a_val  = $urandom;
    b_val  = $urandom;
    ir_val = 16'($urandom);
    run_op1(3'd0, 1'b0);
  endtask

  task automatic test_lui();
    a_val  = $urandom;
    b_val  = $urandom;
    ir_val = 16'h1234;
    run_op1(3'd6, 1'b0);
    total++;
    if (sreg !== 32'h12340000) begin
      bad++;
      $display("FAIL lui_value got=%h want=12340000", sreg);
    end
  endtask

  task automatic test_srav();
    a_val  = 32'h00000004;
    b_val  = 32'h80000000;
    ir_val = 16'($urandom);
    run_op1(3'd5, 1'b0);
    total++;
    if (sreg !== 32'hF8000000) begin
      bad++;
      $display("FAIL srav_value got=%h want=f8000000", sreg);
    end
  endtask

  task automatic test_illegal();
    start1 = 1'b1;
    op1    = 3'd7;
    step();
    total++;
    if (vec1() !== 10'b0010000000) begin
      bad++;
      $display("FAIL illegal got=%h want=080", vec1());
    end
    // run_op1 also checks that err is back to 0 one cycle later.
    a_val  = $urandom;
    b_val  = $urandom;
    ir_val = 16'($urandom);
    run_op1(3'd1, 1'b0);
  endtask

  task automatic test_ignore_busy();
    for (int n = 0; n < 6; n++) begin
      a_val  = $urandom;
      b_val  = $urandom;
      ir_val = 16'($urandom);
      run_op1(3'($urandom_range(0, 6)), 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    start1 = 1'b1;
    op1    = 3'($urandom_range(0, 6));
    step();
    start1 = 1'b0;
    reset  = 1'b1;
    step();
    total++;
    if (vec1() !== 10'h000) begin
      bad++;
      $display("FAIL reset_mid got=%h want=000", vec1());
    end
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      total++;
      if (vec1() !== 10'h000) begin
        bad++;
        $display("FAIL after_reset_mid c=%0d got=%h want=000", j, vec1());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      a_val  = $urandom;
      b_val  = $urandom;
      ir_val = 16'($urandom);
      run_op1(3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  // LOAD_CYCLES=3 with start held high: accepts at k and k+6, dones at
  // k+5 and k+11. Start is dropped so that nothing is sampled at k+12.
  task automatic test_back_to_back();
    logic [2:0] op_a, op_b, op_cur;
    int         dones;
    int         p;
    op_a   = 3'($urandom_range(0, 6));
    op_b   = 3'($urandom_range(0, 6));
    dones  = 0;
    start3 = 1'b1;
    op3    = op_a;
    for (int j = 0; j <= 13; j++) begin
      step();
      op_cur = (j < 6) ? op_a : op_b;
      p      = (j >= 12) ? 0 : (j % 6);
      if (done3) dones++;
      total++;
      if (vec3() !== exp_vec(op_cur, p, 3)) begin
        bad++;
        $display("FAIL b2b j=%0d got=%h want=%h", j, vec3(),
                 exp_vec(op_cur, p, 3));
      end
      if (j == 5)       op3 = op_b;
      else if (j < 5)   op3 = 3'($urandom_range(0, 7));
      else if (j < 11)  op3 = 3'($urandom_range(0, 7));
      if (j == 11) start3 = 1'b0;
    end
    total++;
    if (dones != 2) begin
      bad++;
      $display("FAIL b2b_done_count got=%0d want=2", dones);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_lui();
    test_srav();
    test_illegal();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
